// File: rtl/jtag_ir_ctrl_pkg.sv
// Shared opcodes, data-register select encodings and the instruction decoder
// used by the JTAG instruction register.
package jtag_ir_pkg;

    // Base opcodes; zero-extended to the instruction length at use.
    localparam logic [2:0] OP_EXTEST   = 3'd0;
    localparam logic [2:0] OP_IDCODE   = 3'd1;
    localparam logic [2:0] OP_SAMPLE   = 3'd2;
    localparam logic [2:0] OP_RUNBIST  = 3'd3;
    localparam logic [2:0] OP_CLAMP    = 3'd4;
    localparam logic [2:0] OP_HIGHZ    = 3'd5;
    localparam logic [2:0] OP_USERCODE = 3'd6;

    // Data-register mux select values.
    localparam logic [2:0] DR_BYPASS = 3'b000;
    localparam logic [2:0] DR_ID     = 3'b001;
    localparam logic [2:0] DR_BSR    = 3'b010;
    localparam logic [2:0] DR_BIST   = 3'b011;

    typedef struct packed {
        logic       en_bsc;
        logic       en_bp;
        logic       en_id;
        logic       en_user;
        logic       mode;
        logic       highz;
        logic       bist_mode;
        logic [2:0] dr_sel;
    } ir_dec_t;

    // base_ok is high when every instruction bit above bit 2 is zero; any
    // other code is undefined and falls back to BYPASS behaviour.
    function automatic ir_dec_t ir_decode(input logic base_ok, input logic [2:0] op);
        ir_dec_t d;
        d        = '0;
        d.dr_sel = DR_BYPASS;
        if (!base_ok) begin
            d.en_bp = 1'b1;
        end else begin
            case (op)
                OP_EXTEST:   begin d.en_bsc = 1'b1; d.mode = 1'b1; d.dr_sel = DR_BSR; end
                OP_IDCODE:   begin d.en_id = 1'b1; d.dr_sel = DR_ID; end
                OP_SAMPLE:   begin d.en_bsc = 1'b1; d.dr_sel = DR_BSR; end
                OP_RUNBIST:  begin d.bist_mode = 1'b1; d.dr_sel = DR_BIST; end
                OP_CLAMP:    begin d.en_bp = 1'b1; d.mode = 1'b1; end
                OP_HIGHZ:    begin d.en_bp = 1'b1; d.highz = 1'b1; end
                OP_USERCODE: begin d.en_id = 1'b1; d.en_user = 1'b1; d.dr_sel = DR_ID; end
                default:     d.en_bp = 1'b1;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/jtag_ir_ctrl_if.sv
// TAP-side strobes and decoded instruction outputs of the instruction register.
interface jtag_ir_ctrl_if #(
    parameter int IR_WIDTH = 4
);
    logic                  TLR;
    logic                  Capture_IR;
    logic                  Shift_IR;
    logic                  Update_IR;
    logic                  RTI;
    logic                  TDI;
    logic [IR_WIDTH-3:0]   IR_STATUS;
    logic                  TDO_IR;
    logic [IR_WIDTH-1:0]   I_CODE;
    logic                  EN_BSC;
    logic                  EN_BP;
    logic                  EN_ID;
    logic                  EN_USER;
    logic                  Mode;
    logic                  HIGHZ;
    logic                  BIST_MODE;
    logic                  BIST_DONE;
    logic [2:0]            DR_Sel;

    modport master (
        output TLR, Capture_IR, Shift_IR, Update_IR, RTI, TDI, IR_STATUS,
        input  TDO_IR, I_CODE, EN_BSC, EN_BP, EN_ID, EN_USER, Mode, HIGHZ,
               BIST_MODE, BIST_DONE, DR_Sel
    );

    modport slave (
        input  TLR, Capture_IR, Shift_IR, Update_IR, RTI, TDI, IR_STATUS,
        output TDO_IR, I_CODE, EN_BSC, EN_BP, EN_ID, EN_USER, Mode, HIGHZ,
               BIST_MODE, BIST_DONE, DR_Sel
    );
endinterface

// File: rtl/jtag_ir_ctrl_bist_timer.sv
// RUNBIST cycle timer: counts enabled cycles up to BIST_CYCLES and flags done.
module jtag_bist_timer #(
    parameter int BIST_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);
    localparam int            CW  = $clog2(BIST_CYCLES + 1);
    localparam logic [CW-1:0] MAX = CW'(BIST_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q;

    // Clear wins over count; count saturates at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count only advances under RUNBIST and any instruction write clears it,
    // so reaching MAX already implies RUNBIST is still current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= (cnt_d == MAX);
        end
    end

    assign done_o = done_q;
endmodule

// File: rtl/jtag_ir_ctrl.sv
// JTAG instruction register: capture/shift stage, update register, registered
// instruction decode and RUNBIST done timer.
module jtag_ir_ctrl
    import jtag_ir_pkg::*;
#(
    parameter int IR_WIDTH    = 4,
    parameter int HAS_IDCODE  = 1,
    parameter int BIST_CYCLES = 1024
) (
    input  logic          TCK,
    input  logic          TRST,
    jtag_ir_ctrl_if.slave bus
);
    localparam logic [IR_WIDTH-1:0] RST_CODE =
        (HAS_IDCODE != 0) ? IR_WIDTH'(1) : {IR_WIDTH{1'b1}};
    localparam ir_dec_t RST_DEC =
        ir_decode((RST_CODE >> 3) == '0, RST_CODE[2:0]);

    logic [IR_WIDTH-1:0] ir_sh_q, ir_sh_d;
    logic [IR_WIDTH-1:0] icode_q, icode_d;
    ir_dec_t             dec_q, dec_d;
    logic                icode_wr;
    logic                bist_done;

    // Strobe priority TLR > Capture > Shift > Update; decode follows the next
    // instruction so outputs move on the same edge as I_CODE.
    always_comb begin
        ir_sh_d  = ir_sh_q;
        icode_d  = icode_q;
        icode_wr = 1'b0;
        if (bus.TLR) begin
            icode_d  = RST_CODE;
            icode_wr = 1'b1;
        end else if (bus.Capture_IR) begin
            ir_sh_d = {bus.IR_STATUS, 2'b01};
        end else if (bus.Shift_IR) begin
            ir_sh_d = {bus.TDI, ir_sh_q[IR_WIDTH-1:1]};
        end else if (bus.Update_IR) begin
            icode_d  = ir_sh_q;
            icode_wr = 1'b1;
        end
        dec_d = ir_decode((icode_d >> 3) == '0, icode_d[2:0]);
    end

    // Shift stage, current instruction and decoded outputs.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_sh_q <= '0;
            icode_q <= RST_CODE;
            dec_q   <= RST_DEC;
        end else begin
            ir_sh_q <= ir_sh_d;
            icode_q <= icode_d;
            dec_q   <= dec_d;
        end
    end

    jtag_bist_timer #(
        .BIST_CYCLES(BIST_CYCLES)
    ) u_bist_timer (
        .clk   (TCK),
        .rst_n (TRST),
        .clr_i (icode_wr),
        .en_i  (dec_q.bist_mode && bus.RTI),
        .done_o(bist_done)
    );

    assign bus.TDO_IR    = ir_sh_q[0];
    assign bus.I_CODE    = icode_q;
    assign bus.EN_BSC    = dec_q.en_bsc;
    assign bus.EN_BP     = dec_q.en_bp;
    assign bus.EN_ID     = dec_q.en_id;
    assign bus.EN_USER   = dec_q.en_user;
    assign bus.Mode      = dec_q.mode;
    assign bus.HIGHZ     = dec_q.highz;
    assign bus.BIST_MODE = dec_q.bist_mode;
    assign bus.DR_Sel    = dec_q.dr_sel;
    assign bus.BIST_DONE = bist_done;
endmodule

// File: tb/tb_jtag_ir_ctrl.sv
// Directed bench for jtag_ir_ctrl: two 4-bit instances (IDCODE / BYPASS reset,
// driven identically) and one 8-bit instance.
module tb_jtag_ir_ctrl;
    logic TCK;
    logic TRST;
    int   n_checks = 0;
    int   n_fail   = 0;

    jtag_ir_ctrl_if #(.IR_WIDTH(4)) ifa ();
    jtag_ir_ctrl_if #(.IR_WIDTH(4)) ifb ();
    jtag_ir_ctrl_if #(.IR_WIDTH(8)) ifc ();

    assign ifb.TLR        = ifa.TLR;
    assign ifb.Capture_IR = ifa.Capture_IR;
    assign ifb.Shift_IR   = ifa.Shift_IR;
    assign ifb.Update_IR  = ifa.Update_IR;
    assign ifb.RTI        = ifa.RTI;
    assign ifb.TDI        = ifa.TDI;
    assign ifb.IR_STATUS  = ifa.IR_STATUS;

    jtag_ir_ctrl #(.IR_WIDTH(4), .HAS_IDCODE(1), .BIST_CYCLES(5)) dut_a (
        .TCK(TCK), .TRST(TRST), .bus(ifa));
    jtag_ir_ctrl #(.IR_WIDTH(4), .HAS_IDCODE(0), .BIST_CYCLES(1024)) dut_b (
        .TCK(TCK), .TRST(TRST), .bus(ifb));
    jtag_ir_ctrl #(.IR_WIDTH(8), .HAS_IDCODE(1), .BIST_CYCLES(1024)) dut_c (
        .TCK(TCK), .TRST(TRST), .bus(ifc));

    initial begin
        TCK = 1'b0;
        forever #5 TCK = ~TCK;
    end

    // Expected {EN_BSC,EN_BP,EN_ID,EN_USER,Mode,HIGHZ,BIST_MODE,DR_Sel}
    function automatic logic [9:0] exp_dec(input logic [7:0] code);
        case (code)
            8'h00:   return 10'b1000100_010;
            8'h01:   return 10'b0010000_001;
            8'h02:   return 10'b1000000_010;
            8'h03:   return 10'b0000001_011;
            8'h04:   return 10'b0100100_000;
            8'h05:   return 10'b0100010_000;
            8'h06:   return 10'b0011000_001;
            default: return 10'b0100000_000;
        endcase
    endfunction

    function automatic logic [9:0] obs_a();
        return {ifa.EN_BSC, ifa.EN_BP, ifa.EN_ID, ifa.EN_USER, ifa.Mode,
                ifa.HIGHZ, ifa.BIST_MODE, ifa.DR_Sel};
    endfunction

    function automatic logic [9:0] obs_b();
        return {ifb.EN_BSC, ifb.EN_BP, ifb.EN_ID, ifb.EN_USER, ifb.Mode,
                ifb.HIGHZ, ifb.BIST_MODE, ifb.DR_Sel};
    endfunction

    function automatic logic [9:0] obs_c();
        return {ifc.EN_BSC, ifc.EN_BP, ifc.EN_ID, ifc.EN_USER, ifc.Mode,
                ifc.HIGHZ, ifc.BIST_MODE, ifc.DR_Sel};
    endfunction

    task automatic tick();
        @(posedge TCK);
        #1;
    endtask

    task automatic load_a(input logic [3:0] code);
        ifa.IR_STATUS  = 2'b00;
        ifa.Capture_IR = 1'b1;
        tick();
        ifa.Capture_IR = 1'b0;
        ifa.Shift_IR   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifa.TDI = code[i];
            tick();
        end
        ifa.Shift_IR  = 1'b0;
        ifa.Update_IR = 1'b1;
        tick();
        ifa.Update_IR = 1'b0;
    endtask

    task automatic load_c(input logic [7:0] code);
        ifc.Capture_IR = 1'b1;
        tick();
        ifc.Capture_IR = 1'b0;
        ifc.Shift_IR   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ifc.TDI = code[i];
            tick();
        end
        ifc.Shift_IR  = 1'b0;
        ifc.Update_IR = 1'b1;
        tick();
        ifc.Update_IR = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        n_checks++; if (ifa.I_CODE !== 4'h1) begin n_fail++; $display("FAIL rst_a_icode: got %h want 1", ifa.I_CODE); end
        n_checks++; if (obs_a() !== exp_dec(8'h01)) begin n_fail++; $display("FAIL rst_a_dec: got %b want %b", obs_a(), exp_dec(8'h01)); end
        n_checks++; if (ifa.TDO_IR !== 1'b0) begin n_fail++; $display("FAIL rst_a_tdo: got %b want 0", ifa.TDO_IR); end
        n_checks++; if (ifa.BIST_DONE !== 1'b0) begin n_fail++; $display("FAIL rst_a_done: got %b want 0", ifa.BIST_DONE); end
        n_checks++; if (ifb.I_CODE !== 4'hF) begin n_fail++; $display("FAIL rst_b_icode: got %h want f", ifb.I_CODE); end
        n_checks++; if (obs_b() !== exp_dec(8'hFF)) begin n_fail++; $display("FAIL rst_b_dec: got %b want %b", obs_b(), exp_dec(8'hFF)); end
        n_checks++; if (ifc.I_CODE !== 8'h01) begin n_fail++; $display("FAIL rst_c_icode: got %h want 01", ifc.I_CODE); end
        TRST = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_shift();
        load_a(4'h2);
        n_checks++; if (ifa.I_CODE !== 4'h2) begin n_fail++; $display("FAIL pre_rst_icode: got %h want 2", ifa.I_CODE); end
        ifa.IR_STATUS  = 2'b11;
        ifa.Capture_IR = 1'b1;
        tick();
        ifa.Capture_IR = 1'b0;
        n_checks++; if (ifa.TDO_IR !== 1'b1) begin n_fail++; $display("FAIL pre_rst_tdo: got %b want 1", ifa.TDO_IR); end
        ifa.Shift_IR = 1'b1;
        ifa.TDI      = 1'b1;
        tick();
        tick();
        TRST = 1'b0;
        #1;
        n_checks++; if (ifa.I_CODE !== 4'h1) begin n_fail++; $display("FAIL midrst_a_icode: got %h want 1", ifa.I_CODE); end
        n_checks++; if (obs_a() !== exp_dec(8'h01)) begin n_fail++; $display("FAIL midrst_a_dec: got %b want %b", obs_a(), exp_dec(8'h01)); end
        n_checks++; if (ifa.TDO_IR !== 1'b0) begin n_fail++; $display("FAIL midrst_a_tdo: got %b want 0", ifa.TDO_IR); end
        n_checks++; if (ifb.I_CODE !== 4'hF) begin n_fail++; $display("FAIL midrst_b_icode: got %h want f", ifb.I_CODE); end
        n_checks++; if (ifb.EN_BP !== 1'b1) begin n_fail++; $display("FAIL midrst_b_enbp: got %b want 1", ifb.EN_BP); end
        n_checks++; if (ifb.TDO_IR !== 1'b0) begin n_fail++; $display("FAIL midrst_b_tdo: got %b want 0", ifb.TDO_IR); end
        ifa.Shift_IR = 1'b0;
        ifa.TDI      = 1'b0;
        tick();
        TRST = 1'b1;
        tick();
    endtask

    task automatic test_capture_shift();
        logic [3:0] tdi_seq;
        logic [3:0] tdo_seq;
        tdi_seq = 4'b0010;   // bits applied LSB first: 0,1,0,0
        tdo_seq = 4'b0100;   // TDO after each shift: 0,0,1,0
        ifa.IR_STATUS  = 2'b10;
        ifa.Capture_IR = 1'b1;
        tick();
        ifa.Capture_IR = 1'b0;
        n_checks++; if (ifa.TDO_IR !== 1'b1) begin n_fail++; $display("FAIL cap_tdo: got %b want 1", ifa.TDO_IR); end
        ifa.Shift_IR = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifa.TDI = tdi_seq[i];
            tick();
            n_checks++; if (ifa.TDO_IR !== tdo_seq[i]) begin n_fail++; $display("FAIL shift_tdo[%0d]: got %b want %b", i, ifa.TDO_IR, tdo_seq[i]); end
            n_checks++; if (ifa.I_CODE !== 4'h1) begin n_fail++; $display("FAIL shift_icode[%0d]: got %h want 1", i, ifa.I_CODE); end
        end
        ifa.Shift_IR  = 1'b0;
        ifa.Update_IR = 1'b1;
        tick();
        ifa.Update_IR = 1'b0;
        n_checks++; if (ifa.I_CODE !== 4'h2) begin n_fail++; $display("FAIL upd_icode: got %h want 2", ifa.I_CODE); end
        n_checks++; if (obs_a() !== exp_dec(8'h02)) begin n_fail++; $display("FAIL upd_dec: got %b want %b", obs_a(), exp_dec(8'h02)); end
    endtask

    task automatic test_decode_sweep();
        logic [3:0] prev;
        logic [3:0] code;
        prev = 4'h2;
        for (int c = 0; c < 16; c++) begin
            code = 4'(c);
            ifa.IR_STATUS  = 2'b01;
            ifa.Capture_IR = 1'b1;
            tick();
            ifa.Capture_IR = 1'b0;
            n_checks++; if (obs_a() !== exp_dec({4'h0, prev})) begin n_fail++; $display("FAIL sweep_cap_hold[%0d]: got %b want %b", c, obs_a(), exp_dec({4'h0, prev})); end
            ifa.Shift_IR = 1'b1;
            for (int i = 0; i < 4; i++) begin
                ifa.TDI = code[i];
                tick();
                n_checks++; if (obs_a() !== exp_dec({4'h0, prev})) begin n_fail++; $display("FAIL sweep_shift_hold[%0d.%0d]: got %b want %b", c, i, obs_a(), exp_dec({4'h0, prev})); end
            end
            ifa.Shift_IR  = 1'b0;
            ifa.Update_IR = 1'b1;
            tick();
            ifa.Update_IR = 1'b0;
            n_checks++; if (ifa.I_CODE !== code) begin n_fail++; $display("FAIL sweep_a_icode[%0d]: got %h want %h", c, ifa.I_CODE, code); end
            n_checks++; if (obs_a() !== exp_dec({4'h0, code})) begin n_fail++; $display("FAIL sweep_a_dec[%0d]: got %b want %b", c, obs_a(), exp_dec({4'h0, code})); end
            n_checks++; if (obs_b() !== exp_dec({4'h0, code})) begin n_fail++; $display("FAIL sweep_b_dec[%0d]: got %b want %b", c, obs_b(), exp_dec({4'h0, code})); end
            prev = code;
        end
    endtask

    task automatic test_bist();
        logic [6:0] rti_seq;
        logic [6:0] done_seq;
        rti_seq  = 7'b1100111;   // applied LSB first: 1,1,1,0,0,1,1
        done_seq = 7'b1000000;   // done only after the 5th RTI edge
        load_a(4'h3);
        n_checks++; if (ifa.BIST_MODE !== 1'b1) begin n_fail++; $display("FAIL bist_mode: got %b want 1", ifa.BIST_MODE); end
        for (int i = 0; i < 7; i++) begin
            ifa.RTI = rti_seq[i];
            tick();
            n_checks++; if (ifa.BIST_DONE !== done_seq[i]) begin n_fail++; $display("FAIL bist_done[%0d]: got %b want %b", i, ifa.BIST_DONE, done_seq[i]); end
        end
        ifa.RTI = 1'b0;
        tick();
        tick();
        n_checks++; if (ifa.BIST_DONE !== 1'b1) begin n_fail++; $display("FAIL bist_hold_rti0: got %b want 1", ifa.BIST_DONE); end
        ifa.RTI = 1'b1;
        tick();
        tick();
        n_checks++; if (ifa.BIST_DONE !== 1'b1) begin n_fail++; $display("FAIL bist_saturate: got %b want 1", ifa.BIST_DONE); end
        ifa.RTI = 1'b0;
        load_a(4'hF);
        n_checks++; if (ifa.BIST_DONE !== 1'b0) begin n_fail++; $display("FAIL bist_clr_upd: got %b want 0", ifa.BIST_DONE); end
        n_checks++; if (ifa.BIST_MODE !== 1'b0) begin n_fail++; $display("FAIL bist_mode_off: got %b want 0", ifa.BIST_MODE); end
        load_a(4'h3);
        ifa.RTI = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (ifa.BIST_DONE !== (i == 4)) begin n_fail++; $display("FAIL bist_rerun[%0d]: got %b want %b", i, ifa.BIST_DONE, (i == 4)); end
        end
        ifa.RTI = 1'b0;
        ifa.TLR = 1'b1;
        tick();
        ifa.TLR = 1'b0;
        n_checks++; if (ifa.BIST_DONE !== 1'b0) begin n_fail++; $display("FAIL bist_clr_tlr: got %b want 0", ifa.BIST_DONE); end
        n_checks++; if (ifa.I_CODE !== 4'h1) begin n_fail++; $display("FAIL bist_tlr_icode: got %h want 1", ifa.I_CODE); end
    endtask

    task automatic test_priority();
        load_a(4'h2);
        n_checks++; if (ifa.TDO_IR !== 1'b0) begin n_fail++; $display("FAIL prio_pre_tdo: got %b want 0", ifa.TDO_IR); end
        ifa.IR_STATUS  = 2'b10;
        ifa.Capture_IR = 1'b1;
        ifa.Update_IR  = 1'b1;
        tick();
        ifa.Capture_IR = 1'b0;
        n_checks++; if (ifa.I_CODE !== 4'h2) begin n_fail++; $display("FAIL prio_cap_icode: got %h want 2", ifa.I_CODE); end
        n_checks++; if (ifa.TDO_IR !== 1'b1) begin n_fail++; $display("FAIL prio_cap_tdo: got %b want 1", ifa.TDO_IR); end
        ifa.Shift_IR = 1'b1;
        ifa.TDI      = 1'b1;
        tick();
        ifa.Shift_IR = 1'b0;
        n_checks++; if (ifa.I_CODE !== 4'h2) begin n_fail++; $display("FAIL prio_shift_icode: got %h want 2", ifa.I_CODE); end
        n_checks++; if (ifa.TDO_IR !== 1'b0) begin n_fail++; $display("FAIL prio_shift_tdo: got %b want 0", ifa.TDO_IR); end
        ifa.TLR = 1'b1;
        tick();
        ifa.TLR = 1'b0;
        n_checks++; if (ifa.I_CODE !== 4'h1) begin n_fail++; $display("FAIL prio_tlr_a: got %h want 1", ifa.I_CODE); end
        n_checks++; if (ifb.I_CODE !== 4'hF) begin n_fail++; $display("FAIL prio_tlr_b: got %h want f", ifb.I_CODE); end
        n_checks++; if (ifa.TDO_IR !== 1'b0) begin n_fail++; $display("FAIL prio_tlr_tdo: got %b want 0", ifa.TDO_IR); end
        tick();
        ifa.Update_IR = 1'b0;
        n_checks++; if (ifa.I_CODE !== 4'hC) begin n_fail++; $display("FAIL prio_upd_a: got %h want c", ifa.I_CODE); end
        n_checks++; if (obs_a() !== exp_dec(8'h0C)) begin n_fail++; $display("FAIL prio_upd_dec: got %b want %b", obs_a(), exp_dec(8'h0C)); end
        n_checks++; if (ifb.I_CODE !== 4'hC) begin n_fail++; $display("FAIL prio_upd_b: got %h want c", ifb.I_CODE); end
    endtask

    task automatic test_width8();
        ifc.IR_STATUS  = 6'h2A;
        ifc.Capture_IR = 1'b1;
        tick();
        ifc.Capture_IR = 1'b0;
        n_checks++; if (ifc.TDO_IR !== 1'b1) begin n_fail++; $display("FAIL w8_cap_tdo: got %b want 1", ifc.TDO_IR); end
        load_c(8'h03);
        n_checks++; if (ifc.I_CODE !== 8'h03) begin n_fail++; $display("FAIL w8_icode_03: got %h want 03", ifc.I_CODE); end
        n_checks++; if (obs_c() !== exp_dec(8'h03)) begin n_fail++; $display("FAIL w8_dec_03: got %b want %b", obs_c(), exp_dec(8'h03)); end
        load_c(8'hFF);
        n_checks++; if (ifc.I_CODE !== 8'hFF) begin n_fail++; $display("FAIL w8_icode_ff: got %h want ff", ifc.I_CODE); end
        n_checks++; if (obs_c() !== exp_dec(8'hFF)) begin n_fail++; $display("FAIL w8_dec_ff: got %b want %b", obs_c(), exp_dec(8'hFF)); end
        load_c(8'h13);
        n_checks++; if (obs_c() !== exp_dec(8'h13)) begin n_fail++; $display("FAIL w8_dec_13: got %b want %b", obs_c(), exp_dec(8'h13)); end
    endtask

    initial begin
        TRST = 1'b0;
        ifa.TLR = 1'b0; ifa.Capture_IR = 1'b0; ifa.Shift_IR = 1'b0;
        ifa.Update_IR = 1'b0; ifa.RTI = 1'b0; ifa.TDI = 1'b0; ifa.IR_STATUS = '0;
        ifc.TLR = 1'b0; ifc.Capture_IR = 1'b0; ifc.Shift_IR = 1'b0;
        ifc.Update_IR = 1'b0; ifc.RTI = 1'b0; ifc.TDI = 1'b0; ifc.IR_STATUS = '0;
        test_reset();
        test_reset_mid_shift();
        test_capture_shift();
        test_decode_sweep();
        test_bist();
        test_priority();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
